// File: rtl/md_unit_if.sv
// EX-stage to multiply/divide unit bundle.
// Issue controls and operands in; busy and HI/LO out.
interface md_unit_if;
  logic        MDStart;
  logic [2:0]  MDOp;
  logic        MDFlush;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        isbusy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output MDStart, MDOp, MDFlush, rs, rt,
    input  isbusy, HI, LO
  );

  modport slave (
    input  MDStart, MDOp, MDFlush, rs, rt,
    output isbusy, HI, LO
  );
endinterface

// File: rtl/md_unit.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO.
// Ports: clk, rst (sync, active high), bus (slave: issue in; isbusy/HI/LO out).
module md_unit (
  input  logic     clk,
  input  logic     rst,
  md_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_e;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        sgn_q, sgn_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;

  logic        acc;
  logic        is_md;
  logic        dsgn;
  logic        rs_neg;
  logic        rt_neg;
  logic        sa;
  logic        sb;
  logic [63:0] prod;
  logic [32:0] rem_sh;
  logic [32:0] trial;
  logic [31:0] rem_fix;

  assign acc = bus.MDStart & ~bus.MDFlush
             & (state_q == IDLE) & ~rst;
  assign is_md = ~bus.MDOp[2];
  assign bus.isbusy = ~rst
                    & ((state_q != IDLE) | (acc & is_md));
  assign bus.HI = hi_q;
  assign bus.LO = lo_q;

  assign dsgn   = ~bus.MDOp[0];
  assign rs_neg = dsgn & bus.rs[31];
  assign rt_neg = dsgn & bus.rt[31];

  // One 64-bit multiplier: sign-extending the operands
  // gives the signed product modulo 2^64.
  assign sa   = sgn_q & a_q[31];
  assign sb   = sgn_q & b_q[31];
  assign prod = {{32{sa}}, a_q} * {{32{sb}}, b_q};

  // Held remainder is always below the divisor, so 32 bits
  // suffice; only the shifted trial value needs bit 32.
  assign rem_sh = {rem_q, a_q[31]};
  assign trial  = rem_sh - {1'b0, b_q};

  // A zero divisor never fails the trial subtract, so the
  // remainder ends as |rs|; the rs sign then restores rs.
  assign rem_fix = rneg_q ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          unique case (bus.MDOp)
            OP_MULT, OP_MULTU: begin
              a_d     = bus.rs;
              b_d     = bus.rt;
              sgn_d   = (bus.MDOp == OP_MULT);
              state_d = MUL;
            end
            OP_DIV, OP_DIVU: begin
              a_d     = rs_neg ? -bus.rs : bus.rs;
              b_d     = rt_neg ? -bus.rt : bus.rt;
              qneg_d  = rs_neg ^ rt_neg;
              rneg_d  = rs_neg;
              dz_d    = (bus.rt == 32'd0);
              cnt_d   = 6'd0;
              rem_d   = 32'd0;
              state_d = DIV;
            end
            OP_MTHI: hi_d = bus.rs;
            OP_MTLO: lo_d = bus.rs;
            default: ;
          endcase
        end
      end
      MUL: begin
        hi_d    = prod[63:32];
        lo_d    = prod[31:0];
        state_d = IDLE;
      end
      DIV: begin
        // Dividend shifts out the top while quotient
        // bits fill in from the bottom.
        a_d   = {a_q[30:0], ~trial[32]};
        rem_d = trial[32] ? rem_sh[31:0] : trial[31:0];
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = FIX;
      end
      FIX: begin
        lo_d    = dz_q   ? 32'hFFFF_FFFF :
                  qneg_q ? -a_q : a_q;
        hi_d    = rem_fix;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      rem_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      cnt_q   <= 6'd0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

endmodule
